uart_tx_sequencer: RTL

Transmit-side controller for the UART. It accepts a byte plus line configuration through a ready/start handshake, computes parity, and builds the frame. It then sequences the frame onto the serial line at a programmable bit period and signals completion. It sits between the host-side register/FIFO logic and the tx pin, and owns frame timing and sequencing for the transmit path.

---
 rtl/uart_tx_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte and line configuration via a
// ready/start handshake, latches it, and serialises START, 7/8 data bits
// (LSB first), optional parity and 1/2 STOP bits at max(baud_div,1) clocks
// per bit.
//
// Ports:
//   clock        system clock, rising edge
//   rst          asynchronous active-low reset
//   baud_div     clocks per bit (0 behaves as 1)
//   tx_start     send request, taken when tx_ready is high
//   data_in      payload byte, bit 0 sent first
//   data_length  0 = 7 data bits, 1 = 8 data bits
//   parity_type  01 = odd, 10 = even, otherwise none
//   stop_bits    0 = one stop bit, 1 = two stop bits
//   tx_out       serial line, idle high (registered)
//   tx_ready     block idle and able to accept (registered)
//   tx_busy      frame in flight (registered)
//   tx_done      one-cycle pulse after the final stop bit (registered)
module uart_tx_sequencer #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 tx_start,
    input  logic [7:0]           data_in,
    input  logic                 data_length,
    input  logic [1:0]           parity_type,
    input  logic                 stop_bits,
    output logic                 tx_out,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 len8_q, len8_d;
    logic                 has_par_q, has_par_d;
    logic                 par_q, par_d;
    logic                 stop2_q, stop2_d;

    logic                 tx_out_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 bit_end;
    logic [DATA_W-1:0]    data_mask;

    assign bit_end   = (cnt_q == '0);
    assign data_mask = data_length ? 8'hFF : 8'h7F;

    // State register and registered outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            len8_q    <= 1'b0;
            has_par_q <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            len8_q    <= len8_d;
            has_par_q <= has_par_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            tx_out    <= tx_out_d;
            tx_ready  <= ~busy_d;
            tx_busy   <= busy_d;
            tx_done   <= done_d;
        end
    end

    // Next-state, counters and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        len8_d    = len8_q;
        has_par_d = has_par_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    period_d  = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
                    cnt_d     = period_d - DIV_WIDTH'(1);
                    shift_d   = data_in;
                    len8_d    = data_length;
                    has_par_d = (parity_type == 2'b01) || (parity_type == 2'b10);
                    // XOR of data gives even parity; odd parity is its complement
                    par_d     = (^(data_in & data_mask)) ^ (parity_type == 2'b01);
                    stop2_d   = stop_bits;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = period_q - DIV_WIDTH'(1);
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = period_q - DIV_WIDTH'(1);
                    if (idx_q == (len8_q ? IDX_W'(7) : IDX_W'(6))) begin
                        idx_d   = '0;
                        state_d = has_par_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = period_q - DIV_WIDTH'(1);
                    idx_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = period_q - DIV_WIDTH'(1);
                    if (idx_q == IDX_W'(stop2_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so it is registered
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = par_q;
            default:  tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

endmodule
